plic_lite: RTL and testbench
============================

Name: plic_lite

Overview:
- Platform-level interrupt controller feeding the core's external-interrupt port.
- Gathers up to NSRC level-sensitive peripheral interrupt lines and gates each one.
- Picks the highest-priority enabled pending source above a threshold and offers it to the trap unit on a valid/ready handshake. The source stays locked until the core signals completion after MRET.
- Configured through a small memory-mapped register slave on the peripheral bus.

Parameters:
- NSRC, 16, number of interrupt sources, legal 1..16; IDs 0..NSRC-1 map to mcause 4..NSRC+3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- src_i  in  NSRC  level-sensitive interrupt requests, already synchronous to clk.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  5  byte address; bits [4:2] select the register.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, combinational from reg_addr_i.
- ex_trap_valid_o  out  1  external interrupt offered to the core.
- ex_trap_id_o  out  5  ID of the offered source.
- ex_trap_ready_i  in  1  one-cycle claim pulse from the core.
- ex_trap_cplet_i  in  1  one-cycle completion pulse from the core.
- ex_trap_cplet_id_i  in  5  ID being completed.

Behaviour:
- Reset: one clock is used; rst_n is synchronous and active-low. On reset all registers clear: enable, pending, busy, priorities, threshold and id_r. State = IDLE. ex_trap_valid_o=0, ex_trap_id_o=0.
- Register map (word index = addr[4:2]):
  - 0 ENABLE: RW, bits [NSRC-1:0].
  - 1 PENDING: RO.
  - 2 PRIO0: RW, 4-bit field per source 0..7, field k at [4k+3:4k].
  - 3 PRIO1: RW, sources 8..15.
  - 4 THRESHOLD: RW, [3:0].
  - 5 CLAIMED: RO, {busy_valid at bit 31, busy id at [4:0]}.
  - Unimplemented bits and indices read 0 and ignore writes. Fields for sources >= NSRC read 0.
- Gateway, per source i:
  - pending[i] sets on the clock after src_i[i]=1 while pending[i]=0 and busy[i]=0.
  - Dropping src_i[i] does not clear pending[i].
  - pending[i] clears only on claim.
- Arbiter (combinational):
  - Candidate = pending & enable & (prio > threshold). Priority 0 is never eligible.
  - Winner = highest prio; ties go to the lowest ID.
- State machine:
  - IDLE: if a candidate exists, latch winner into id_r and go to OFFER. ex_trap_valid_o=0.
  - OFFER: ex_trap_valid_o=1 and ex_trap_id_o=id_r, both frozen regardless of register writes or new sources. On ex_trap_ready_i: clear pending[id_r], set busy[id_r], go to WAIT_CPL.
  - WAIT_CPL: ex_trap_valid_o=0. On ex_trap_cplet_i with ex_trap_cplet_id_i==id_r: clear busy, go to IDLE. A mismatching ID is ignored.
- Latency: src_i rising at cycle t gives pending at t+1 and ex_trap_valid_o at t+2. After a matching completion, the next offer is no earlier than 2 cycles later.
- Only one claim is ever outstanding (the core masks MIE while servicing).
- ex_trap_ready_i outside OFFER and ex_trap_cplet_i outside WAIT_CPL are ignored.
- Simultaneous events:
  - Register write and claim in the same cycle: both take effect.
  - A PRIO/ENABLE change during OFFER does not withdraw the offer.
  - src_i high on the same cycle busy clears: pending sets on the following cycle.
- Reset asserted mid-OFFER or mid-WAIT_CPL: return to IDLE with valid=0 next clock; all state is lost.

Test Plan:
- ENABLE=0x0004, PRIO0=0x00000300, THRESHOLD=0, pulse src_i[2] at t → valid=1, id=2 at t+2. Ready pulse → valid=0, PENDING bit 2=0, CLAIMED=0x80000002. Cplet id=2 → CLAIMED=0.
- Sources 3 (prio 5) and 9 (prio 5) plus 1 (prio 2), all enabled and pending together → offers in order 3, 9, 1, each after its completion.
- THRESHOLD=4, source 0 prio 4 pending and enabled → valid stays 0. Write THRESHOLD=3 → valid=1, id=0 two cycles later.
- In OFFER with id=5, write ENABLE=0 → valid and id=5 held. Ready still claims 5.
- In WAIT_CPL for id=7: cplet id=6 → stays busy. src_i[7] held high → no new pending. Cplet id=7 → busy clears, pending[7] sets next cycle, re-offer.
- Assert rst_n=0 for one cycle during WAIT_CPL → next clock valid=0, all registers read 0.

Source files
------------

// File: rtl/plic_lite.sv
// Lightweight platform interrupt controller: level gateways, priority arbiter,
// and a single-claim offer/complete handshake toward the core's trap unit.
module plic_lite #(
    parameter int NSRC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src_i,
    input  logic            reg_we_i,
    input  logic [4:0]      reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    output logic            ex_trap_valid_o,
    output logic [4:0]      ex_trap_id_o,
    input  logic            ex_trap_ready_i,
    input  logic            ex_trap_cplet_i,
    input  logic [4:0]      ex_trap_cplet_id_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_CPL = 2'd2
    } state_e;

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NSRC) - 32'd1);

    localparam logic [2:0] IDX_ENABLE    = 3'd0;
    localparam logic [2:0] IDX_PENDING   = 3'd1;
    localparam logic [2:0] IDX_PRIO0     = 3'd2;
    localparam logic [2:0] IDX_PRIO1     = 3'd3;
    localparam logic [2:0] IDX_THRESHOLD = 3'd4;
    localparam logic [2:0] IDX_CLAIMED   = 3'd5;

    state_e            state_q, state_d;
    logic [15:0]       enable_q, enable_d;
    logic [15:0]       pending_q, pending_d;
    logic [15:0][3:0]  prio_q, prio_d;
    logic [3:0]        threshold_q, threshold_d;
    logic [4:0]        id_q, id_d;

    logic [15:0]       src_ext;
    logic [15:0]       busy_vec;
    logic [15:0]       claim_vec;
    logic              busy_vld;
    logic              claim;
    logic              win_vld;
    logic [4:0]        win_id;
    logic [3:0]        best_prio;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^reg_addr_i[1:0];
    assign src_ext         = 16'(src_i) & SRC_MASK;

    // Only one claim is ever outstanding, so busy is implied by WAIT_CPL and id_q.
    assign busy_vld  = (state_q == WAIT_CPL);
    assign busy_vec  = busy_vld ? (16'd1 << id_q) : 16'd0;
    assign claim_vec = claim    ? (16'd1 << id_q) : 16'd0;

    // Strict compare while scanning upward keeps the lowest ID on priority ties;
    // seeding with the threshold excludes priority 0 and anything at/below it.
    always_comb begin
        best_prio = threshold_q;
        win_vld   = 1'b0;
        win_id    = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (enable_q[i] && pending_q[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                win_vld   = 1'b1;
                win_id    = 5'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        claim   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ex_trap_ready_i) begin
                    claim   = 1'b1;
                    state_d = WAIT_CPL;
                end
            end
            WAIT_CPL: begin
                if (ex_trap_cplet_i && (ex_trap_cplet_id_i == id_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gateway: a set needs the bit clear and the source not in service.
    assign pending_d = (pending_q & ~claim_vec) | (src_ext & ~pending_q & ~busy_vec);

    always_comb begin
        enable_d    = enable_q;
        prio_d      = prio_q;
        threshold_d = threshold_q;
        if (reg_we_i) begin
            case (reg_addr_i[4:2])
                IDX_ENABLE:    enable_d    = reg_wdata_i[15:0] & SRC_MASK;
                IDX_PRIO0:     prio_d[7:0] = reg_wdata_i;
                IDX_PRIO1:     prio_d[15:8] = reg_wdata_i;
                IDX_THRESHOLD: threshold_d = reg_wdata_i[3:0];
                default:       ;
            endcase
        end
        for (int k = 0; k < 16; k++) begin
            if (k >= NSRC) begin
                prio_d[k] = 4'd0;
            end
        end
    end

    always_comb begin
        reg_rdata_o = 32'd0;
        case (reg_addr_i[4:2])
            IDX_ENABLE:    reg_rdata_o = {16'd0, enable_q};
            IDX_PENDING:   reg_rdata_o = {16'd0, pending_q};
            IDX_PRIO0:     reg_rdata_o = prio_q[7:0];
            IDX_PRIO1:     reg_rdata_o = prio_q[15:8];
            IDX_THRESHOLD: reg_rdata_o = {28'd0, threshold_q};
            IDX_CLAIMED:   reg_rdata_o = busy_vld ? {1'b1, 26'd0, id_q} : 32'd0;
            default:       reg_rdata_o = 32'd0;
        endcase
    end

    assign ex_trap_valid_o = (state_q == OFFER);
    assign ex_trap_id_o    = (state_q == OFFER) ? id_q : 5'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enable_q    <= 16'd0;
            pending_q   <= 16'd0;
            prio_q      <= '0;
            threshold_q <= 4'd0;
            id_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            prio_q      <= prio_d;
            threshold_q <= threshold_d;
            id_q        <= id_d;
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: register access, gateway, arbitration order,
// threshold gating, frozen offers, completion ID matching and mid-service reset.
module tb_plic_lite;

    localparam int NSRC = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] src_i;
    logic            reg_we_i;
    logic [4:0]      reg_addr_i;
    logic [31:0]     reg_wdata_i;
    logic [31:0]     reg_rdata_o;
    logic            ex_trap_valid_o;
    logic [4:0]      ex_trap_id_o;
    logic            ex_trap_ready_i;
    logic            ex_trap_cplet_i;
    logic [4:0]      ex_trap_cplet_id_i;

    int n_cmp = 0;
    int n_bad = 0;

    plic_lite #(.NSRC(NSRC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .src_i              (src_i),
        .reg_we_i           (reg_we_i),
        .reg_addr_i         (reg_addr_i),
        .reg_wdata_i        (reg_wdata_i),
        .reg_rdata_o        (reg_rdata_o),
        .ex_trap_valid_o    (ex_trap_valid_o),
        .ex_trap_id_o       (ex_trap_id_o),
        .ex_trap_ready_i    (ex_trap_ready_i),
        .ex_trap_cplet_i    (ex_trap_cplet_i),
        .ex_trap_cplet_id_i (ex_trap_cplet_id_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data);
        reg_we_i    = 1'b1;
        reg_addr_i  = {idx, 2'b00};
        reg_wdata_i = data;
        tick();
        reg_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] data);
        reg_addr_i = {idx, 2'b00};
        #1;
        data = reg_rdata_o;
    endtask

    task automatic claim();
        ex_trap_ready_i = 1'b1;
        tick();
        ex_trap_ready_i = 1'b0;
    endtask

    task automatic complete(input logic [4:0] id);
        ex_trap_cplet_i    = 1'b1;
        ex_trap_cplet_id_i = id;
        tick();
        ex_trap_cplet_i    = 1'b0;
        ex_trap_cplet_id_i = 5'd0;
    endtask

    logic [31:0] r;
    logic [4:0]  order [3];

    initial begin
        rst_n = 1'b0; src_i = '0; reg_we_i = 1'b0; reg_addr_i = 5'd0; reg_wdata_i = 32'd0;
        ex_trap_ready_i = 1'b0; ex_trap_cplet_i = 1'b0; ex_trap_cplet_id_i = 5'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_valid", 32'(ex_trap_valid_o), 32'd0);
        check("rst_id", 32'(ex_trap_id_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), r);
            check($sformatf("rst_reg%0d", i), r, 32'd0);
        end

        // Upper and unimplemented bits ignore writes
        wr(3'd0, 32'hFFFF_FFFF); rd(3'd0, r); check("enable_mask", r, 32'h0000_FFFF);
        wr(3'd4, 32'hFFFF_FFF0); rd(3'd4, r); check("thresh_mask", r, 32'd0);
        wr(3'd6, 32'h1234_5678); rd(3'd6, r); check("unimpl_idx", r, 32'd0);

        // Basic offer / claim / complete on source 2
        wr(3'd0, 32'h0000_0004);
        wr(3'd2, 32'h0000_0300);
        src_i[2] = 1'b1;
        tick();
        src_i[2] = 1'b0;
        rd(3'd1, r); check("t1_pending", r, 32'h0000_0004);
        check("t1_valid_t1", 32'(ex_trap_valid_o), 32'd0);
        tick();
        check("t1_valid_t2", 32'(ex_trap_valid_o), 32'd1);
        check("t1_id", 32'(ex_trap_id_o), 32'd2);
        claim();
        check("t1_valid_claimed", 32'(ex_trap_valid_o), 32'd0);
        rd(3'd1, r); check("t1_pending_clr", r, 32'd0);
        rd(3'd5, r); check("t1_claimed", r, 32'h8000_0002);
        complete(5'd2);
        rd(3'd5, r); check("t1_claimed_clr", r, 32'd0);

        // Priority order with a tie: 3 (p5), 9 (p5), 1 (p2)
        wr(3'd0, 32'h0000_020A);
        wr(3'd2, 32'h0000_5020);
        wr(3'd3, 32'h0000_0050);
        src_i = 16'h020A;
        tick();
        src_i = '0;
        rd(3'd1, r); check("t2_pending", r, 32'h0000_020A);
        tick();
        order[0] = 5'd3; order[1] = 5'd9; order[2] = 5'd1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_valid%0d", k), 32'(ex_trap_valid_o), 32'd1);
            check($sformatf("t2_id%0d", k), 32'(ex_trap_id_o), 32'(order[k]));
            claim();
            complete(order[k]);
            check($sformatf("t2_gap%0d", k), 32'(ex_trap_valid_o), 32'd0);
            tick();
        end
        check("t2_idle", 32'(ex_trap_valid_o), 32'd0);

        // Threshold gating: prio 4 at threshold 4 is not eligible
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h0000_0001);
        wr(3'd2, 32'h0000_0004);
        wr(3'd4, 32'h0000_0004);
        src_i[0] = 1'b1;
        tick();
        src_i[0] = 1'b0;
        tick(); tick();
        check("t3_blocked", 32'(ex_trap_valid_o), 32'd0);
        claim();
        rd(3'd1, r); check("t3_ready_ignored", r, 32'h0000_0001);
        wr(3'd4, 32'h0000_0003);
        check("t3_valid_t1", 32'(ex_trap_valid_o), 32'd0);
        tick();
        check("t3_valid_t2", 32'(ex_trap_valid_o), 32'd1);
        check("t3_id", 32'(ex_trap_id_o), 32'd0);
        claim();
        complete(5'd0);
        wr(3'd4, 32'd0);

        // Offer stays frozen across an ENABLE write
        wr(3'd0, 32'h0000_0020);
        wr(3'd2, 32'h0010_0000);
        src_i[5] = 1'b1;
        tick();
        src_i[5] = 1'b0;
        tick();
        check("t4_id", 32'(ex_trap_id_o), 32'd5);
        wr(3'd0, 32'd0);
        check("t4_valid_held", 32'(ex_trap_valid_o), 32'd1);
        check("t4_id_held", 32'(ex_trap_id_o), 32'd5);
        claim();
        rd(3'd5, r); check("t4_claimed", r, 32'h8000_0005);
        complete(5'd5);
        tick();
        check("t4_idle", 32'(ex_trap_valid_o), 32'd0);

        // Completion ID matching and gateway blocking while busy
        wr(3'd0, 32'h0000_0080);
        wr(3'd2, 32'h1000_0000);
        src_i[7] = 1'b1;
        tick(); tick();
        check("t5_id", 32'(ex_trap_id_o), 32'd7);
        claim();
        tick();
        rd(3'd1, r); check("t5_no_pending_busy", r, 32'd0);
        complete(5'd6);
        rd(3'd5, r); check("t5_wrong_cplet", r, 32'h8000_0007);
        complete(5'd7);
        rd(3'd5, r); check("t5_busy_clr", r, 32'd0);
        rd(3'd1, r); check("t5_pending_same", r, 32'd0);
        tick();
        rd(3'd1, r); check("t5_pending_next", r, 32'h0000_0080);
        check("t5_valid_not_yet", 32'(ex_trap_valid_o), 32'd0);
        tick();
        check("t5_reoffer", 32'(ex_trap_valid_o), 32'd1);
        check("t5_reoffer_id", 32'(ex_trap_id_o), 32'd7);
        claim();
        src_i[7] = 1'b0;

        // Reset during WAIT_CPL
        rd(3'd5, r); check("t6_pre_claimed", r, 32'h8000_0007);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", 32'(ex_trap_valid_o), 32'd0);
        check("t6_id", 32'(ex_trap_id_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), r);
            check($sformatf("t6_reg%0d", i), r, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
